// File: rtl/tipi_reader_pkg.sv
// Shared constants, state encoding and parity helper for the TIPI register read-out engine.
package tipi_reader_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  // Index of the final bit in a transfer: data only, or data plus parity.
  localparam logic [CNT_W-1:0] LAST_PLAIN  = 4'd7;
  localparam logic [CNT_W-1:0] LAST_PARITY = 4'd8;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [0:BYTE_W-1] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/tipi_reg_reader_if.sv
// Pi-side GPIO bundle: strobes and select driven by the Pi, serial data and status back.
interface tipi_reg_reader_if;
  logic r_reg;
  logic r_le;
  logic r_clk;
  logic r_dout;
  logic busy;
  logic done;

  modport master (output r_reg, r_le, r_clk, input r_dout, busy, done);
  modport slave  (input r_reg, r_le, r_clk, output r_dout, busy, done);
endinterface

// File: rtl/tipi_reg_reader_sync_edge.sv
// Multi-flop synchronizer for an asynchronous Pi strobe with a registered rising-edge pulse.
module tipi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  if (STAGES < 2) begin : g_bad_stages
    $error("tipi_sync_edge: STAGES must be at least 2");
  end

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_rise;

endmodule

// File: rtl/tipi_reg_reader.sv
// Serial read-out of the TI-side td/tc latches to the Pi, bit 0 first.
// Define TIPI_READER_PARITY_EN to append an odd-parity bit (9-bit transfer).
module tipi_reg_reader
  import tipi_reader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [0:BYTE_W-1] i_td,
  input  logic [0:BYTE_W-1] i_tc,
  tipi_reg_reader_if.slave  pi
);

`ifdef TIPI_READER_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = LAST_PARITY;
`else
  localparam logic [CNT_W-1:0] LAST = LAST_PLAIN;
`endif
  localparam int XFER_W = int'(LAST) + 1;

  logic w_le_rise, w_clk_rise;
  logic w_le_lvl, w_clk_lvl;
  logic w_unused_lvl;

  tipi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_le (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (pi.r_le),
    .o_level (w_le_lvl),
    .o_rise  (w_le_rise)
  );

  tipi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (pi.r_clk),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise)
  );

  assign w_unused_lvl = w_le_lvl ^ w_clk_lvl;

  // Register select only needs a stable level; the Pi holds it ahead of r_le.
  logic [SYNC_STAGES-1:0] r_sel_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_sel_sync <= '0;
    else         r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], pi.r_reg};
  end

  logic [0:BYTE_W-1] w_sel;
  logic [0:XFER_W-1] w_snap;

  assign w_sel = r_sel_sync[SYNC_STAGES-1] ? i_tc : i_td;

`ifdef TIPI_READER_PARITY_EN
  assign w_snap = {w_sel, odd_par(w_sel)};
`else
  assign w_snap = w_sel;
`endif

  state_e            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [0:XFER_W-1] r_sh, w_sh;
  logic              r_sdo, w_sdo;
  logic              r_busy, w_busy;
  logic              r_done, w_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_sdo   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_sdo   <= w_sdo;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // A load strobe takes priority over everything, so a coincident shift edge is dropped.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sh    = r_sh;
    w_sdo   = r_sdo;
    w_busy  = r_busy;
    w_done  = 1'b0;
    if (w_le_rise) begin
      w_state = ST_SHIFT;
      w_cnt   = '0;
      w_sh    = w_snap;
      w_sdo   = w_snap[0];
      w_busy  = 1'b1;
    end else if (r_state == ST_SHIFT && w_clk_rise) begin
      if (r_cnt == LAST) begin
        w_state = ST_IDLE;
        w_cnt   = '0;
        w_sh    = '0;
        w_sdo   = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b1;
      end else begin
        w_sh    = {r_sh[1:XFER_W-1], 1'b0};
        w_cnt   = r_cnt + 1'b1;
        w_sdo   = r_sh[1];
      end
    end
  end

  assign pi.r_dout = r_sdo;
  assign pi.busy   = r_busy;
  assign pi.done   = r_done;

endmodule

// File: tb/tb_tipi_reg_reader.sv
// Directed bench for tipi_reg_reader: vector table of transfers plus hand-written corner sequences.
module tb_tipi_reg_reader;

`ifdef TIPI_READER_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [0:7] td, tc;

  tipi_reg_reader_if pi();

  tipi_reg_reader #(.SYNC_STAGES(2)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_td    (td),
    .i_tc    (tc),
    .pi      (pi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(posedge clk) if (pi.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic le_pulse();
    pi.r_le = 1'b1; hold(6);
    pi.r_le = 1'b0; hold(6);
  endtask

  task automatic clk_pulse();
    pi.r_clk = 1'b1; hold(6);
    pi.r_clk = 1'b0; hold(6);
  endtask

  // Walks a loaded transfer to completion; seq is listed in transfer order, MSB = first bit.
  task automatic run_xfer(input string nm, input logic [7:0] seq, input logic par);
    int   d0;
    logic e;
    d0 = done_cnt;
    for (int i = 0; i < NBITS; i++) begin
      e = (i < 8) ? seq[7-i] : par;
      chk($sformatf("%s bit%0d", nm, i), pi.r_dout, e);
      if (i == NBITS - 1) chk($sformatf("%s no early done", nm), done_cnt, d0);
      clk_pulse();
    end
    chk({nm, " done once"}, done_cnt, d0 + 1);
    chk({nm, " busy low"}, pi.busy, 1'b0);
    chk({nm, " dout low"}, pi.r_dout, 1'b0);
  endtask

  typedef struct {
    logic [7:0] td;
    logic [7:0] tc;
    logic       sel;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0;
    vecs[0] = '{8'hAA, 8'h55, 1'b0, 8'b1010_1010, 1'b1};
    vecs[1] = '{8'h12, 8'h81, 1'b1, 8'b1000_0001, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 8'b1111_1111, 1'b1};
    vecs[3] = '{8'h5A, 8'h01, 1'b1, 8'b0000_0001, 1'b0};
    vecs[4] = '{8'h7F, 8'hC3, 1'b0, 8'b0111_1111, 1'b0};
    vecs[5] = '{8'h00, 8'h3C, 1'b1, 8'b0011_1100, 1'b1};

    reset = 1'b1;
    pi.r_le = 1'b0; pi.r_clk = 1'b0; pi.r_reg = 1'b0;
    td = 8'h00; tc = 8'h00;
    hold(4);
    chk("reset dout", pi.r_dout, 1'b0);
    chk("reset busy", pi.busy, 1'b0);
    chk("reset done", pi.done, 1'b0);
    reset = 1'b0;
    hold(2);

    // Shift clocks with nothing loaded must be ignored.
    for (int i = 0; i < 3; i++) begin
      clk_pulse();
      chk($sformatf("idle clk%0d dout", i), pi.r_dout, 1'b0);
      chk($sformatf("idle clk%0d busy", i), pi.busy, 1'b0);
    end
    chk("idle no done", done_cnt, 0);

    // Pin-to-output latency: busy rises on the 4th clk edge after r_le.
    td = 8'hAA; pi.r_reg = 1'b0; hold(4);
    pi.r_le = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("latency busy early", pi.busy, 1'b0);
    @(posedge clk);
    #1 chk("latency busy", pi.busy, 1'b1);
    chk("latency dout", pi.r_dout, 1'b1);
    hold(6); pi.r_le = 1'b0; hold(6);
    run_xfer("lat AA", 8'b1010_1010, 1'b1);

    foreach (vecs[k]) begin
      td = vecs[k].td; tc = vecs[k].tc; pi.r_reg = vecs[k].sel;
      hold(4);
      le_pulse();
      chk($sformatf("vec%0d busy", k), pi.busy, 1'b1);
      run_xfer($sformatf("vec%0d", k), vecs[k].seq, vecs[k].par);
    end

    // Snapshot isolation from later latch changes.
    tc = 8'h81; pi.r_reg = 1'b1; hold(4);
    le_pulse();
    tc = 8'h00; td = 8'hFF;
    run_xfer("isolate", 8'b1000_0001, 1'b1);

    // Abort after 3 bits and reload with a new value.
    td = 8'hF0; pi.r_reg = 1'b0; hold(4);
    le_pulse();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort pre bit%0d", i), pi.r_dout, 1'b1);
      clk_pulse();
    end
    td = 8'h0F; hold(2);
    le_pulse();
    chk("abort no done", done_cnt, d0);
    run_xfer("reload", 8'b0000_1111, 1'b1);
    chk("abort total done", done_cnt, d0 + 1);

    // Coincident load and shift edge: load wins, count restarts.
    td = 8'h3C; hold(4);
    le_pulse();
    clk_pulse(); clk_pulse();
    td = 8'h80; hold(4);
    pi.r_le = 1'b1; pi.r_clk = 1'b1; hold(6);
    pi.r_le = 1'b0; pi.r_clk = 1'b0; hold(6);
    chk("same-cycle busy", pi.busy, 1'b1);
    run_xfer("same-cycle", 8'b1000_0000, 1'b0);

    // Reset mid-transfer.
    td = 8'hFF; hold(4);
    le_pulse();
    clk_pulse(); clk_pulse();
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1 chk("midrst dout", pi.r_dout, 1'b0);
    chk("midrst busy", pi.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    hold(2);
    clk_pulse();
    chk("midrst post clk dout", pi.r_dout, 1'b0);
    chk("midrst post clk busy", pi.busy, 1'b0);
    chk("midrst no done", done_cnt, d0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
